lut_decoder_driver: RTL and testbench
=====================================

# lut_decoder_driver

Sequential stimulus source for the BKM LUT decoder: sweeps every legal `(mode, format, n, d_x_n, d_y_n)` combination and presents one vector per transfer on a valid/ready interface. Sits in the `lut_decoder` verification environment between the bench controller and the DUT/checker pair. It is the transmitting end of the `tb_*` vector stream that `lut_decoder_checker` consumes. Synthesizable, so it can also drive on-FPGA self-test of the decoder.

## Interface
- `WC`, 16, width of u/v LUT words (pass-through only, for vector sizing consistency)
- `WD`, 64, width of X/Y LUT words (pass-through only)
- `LOG2N`, 6, width of iteration index `tb_n`
- `N_LAST`, 2**LOG2N-1, last iteration index swept (inclusive)
- `WCNT`, 16, width of vector counter

- `clk` in 1: single clock, rising edge
- `arst` in 1: reset, asynchronous, active-low (asserted when 0)
- `srst` in 1: synchronous reset, active-high, same effect as `arst`
- `enable` in 1: global clock enable; 0 freezes all state
- `start` in 1: begin sweep (sampled in IDLE or DONE only)
- `ready` in 1: consumer accepts current vector
- `valid` out 1: current vector is valid
- `tb_mode` out 1: 0 = E-mode, 1 = L-mode
- `tb_format` out 2: operand format, legal 00/01/10
- `tb_n` out LOG2N: iteration index
- `tb_d_x_n` out 2: BKM digit, encoding 00=0, 01=+1, 11=−1
- `tb_d_y_n` out 2: same encoding
- `vec_cnt` out WCNT: number of accepted vectors since start
- `busy` out 1: FSM in RUN
- `done` out 1: sweep complete, held until next start or reset

## Operation
- FSM states:
  - IDLE → RUN on `start`.
  - RUN → DONE on acceptance of the last vector.
  - DONE → RUN on `start`.
  - Any state → IDLE on reset.
- Transfer occurs when `valid & ready & enable` are all 1.
- Nesting order, innermost first: `d_y`, `d_x`, `n`, `format`, `mode`.
- Digit sequence is 00 → 01 → 11 → 00 (wrap). On wrap, `d_y` carries into `d_x`, and `d_x` carries into `n`.
- `n` counts 0..`N_LAST`. On wrap to 0 it carries into `format`.
- `format` sequence is 00 → 01 → 10 → 00. Format 11 is never emitted. On wrap it carries into `mode`.
- The last vector is: mode=1, format=10, n=`N_LAST`, d_x=11, d_y=11.
- Total vectors = 2·3·(`N_LAST`+1)·9.
- `vec_cnt` increments by 1 per transfer and saturates at all-ones. It is cleared on entry to RUN.
- On entry to RUN, the vector fields load to all-zero (mode 0, format 00, n 0, digits 00).
- `start` while in RUN is ignored.
- `start` in DONE clears `done` and restarts the sweep from zero.
- `enable`=0 freezes the FSM, fields and counter, and blocks transfers. Outputs hold their values.
- Reset values for all outputs: `valid`=0, `busy`=0, `done`=0, `vec_cnt`=0, and all `tb_*` fields 0.
- Reset asserted mid-sweep aborts the sweep immediately with no completion flag. A new `start` is required.
- While `valid`=1 and `ready`=0, all `tb_*` outputs are held stable (AXI-style; no retraction).

## Timing
- All outputs are registered.
- Cycle 0: `start`=1 in IDLE with `enable`=1.
- Cycle 1: `valid`=1, `busy`=1, first vector on the outputs.
- With `ready` held at 1, a new vector appears every cycle. Throughput is 1 vector/clk.
- Edge k is the edge on which the last transfer occurs. In cycle k+1: `valid`=0, `busy`=0, `done`=1, `vec_cnt`=total.
- `done` and `start` in the same cycle while in DONE: the restart wins, and `done`=0 in the next cycle.
- `ready` is a don't-care while `valid`=0.
- The `arst` deassertion edge must be synchronized externally. The block only guarantees async assertion.

## Test plan
- Reset check: `arst`=0 with `start`=1 → all outputs 0. Release `arst`, assert `start`, with `ready`=1 and `LOG2N`=2, `N_LAST`=3 → `valid` rises 1 cycle later, first vector all-zero, `done` after 216 transfers, `vec_cnt`=216.
- Order check (same config, ready=1):
  - Vectors 0..8 → (d_x,d_y) = 00/00, 00/01, 00/11, 01/00, …, 11/11, with n=0.
  - Vector 9 → n=1.
  - Vector 36 → format=01.
  - Vector 108 → mode=1.
  - Format 11 is never emitted.
- Backpressure: drive `ready` with a random 50% pattern → the checker sees 216 unique vectors in order, and `tb_*` stays stable across every `ready`=0 cycle.
- Enable freeze: deassert `enable` for 5 cycles at vector 50 with `ready`=1 → `vec_cnt` holds at 50, no transfer occurs, and the sweep resumes with vector 50 unchanged.
- Mid-sweep reset: pulse `srst` at vector 100 → next cycle IDLE, `valid`=0, `done`=0, `vec_cnt`=0. Then `start` → the sweep restarts at the all-zero vector.
- Restart from DONE: `start` while `done`=1 → `done` clears, a second full sweep completes, and `vec_cnt`=216 again. A `start` pulse issued mid-RUN has no effect.

Source files
------------

// File: rtl/lut_decoder_driver.sv
// lut_decoder_driver
// Sequential stimulus source for the BKM LUT decoder. Sweeps every legal
// (mode, format, n, d_x_n, d_y_n) combination, innermost d_y first, and presents
// one vector per transfer on a valid/ready interface.
//
// Ports:
//   clk        - single clock, rising edge
//   arst       - asynchronous reset, active-low
//   srst       - synchronous reset, active-high, same effect as arst
//   enable     - global clock enable; 0 freezes all state
//   start      - begin a sweep (honoured in IDLE or DONE only)
//   ready      - consumer accepts the current vector
//   valid      - current vector is valid
//   tb_mode    - 0 = E-mode, 1 = L-mode
//   tb_format  - operand format, 00/01/10
//   tb_n       - iteration index 0..N_LAST
//   tb_d_x_n   - BKM digit, 00=0, 01=+1, 11=-1
//   tb_d_y_n   - BKM digit, same encoding
//   vec_cnt    - accepted vectors since start (saturating)
//   busy       - sweep in progress
//   done       - sweep complete, held until next start or reset

module lut_decoder_driver #(
   parameter int unsigned WC     = 16,
   parameter int unsigned WD     = 64,
   parameter int unsigned LOG2N  = 6,
   parameter int unsigned N_LAST = 2**LOG2N - 1,
   parameter int unsigned WCNT   = 16
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             srst,
   input  logic             enable,
   input  logic             start,
   input  logic             ready,
   output logic             valid,
   output logic             tb_mode,
   output logic [1:0]       tb_format,
   output logic [LOG2N-1:0] tb_n,
   output logic [1:0]       tb_d_x_n,
   output logic [1:0]       tb_d_y_n,
   output logic [WCNT-1:0]  vec_cnt,
   output logic             busy,
   output logic             done
);

   // WC/WD only keep vector sizing consistent with the decoder; nothing here depends on them.
   if (WC == 0 || WD == 0) begin : g_bad_width
   end

   localparam logic [LOG2N-1:0] NLast = LOG2N'(N_LAST);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e state;
   logic   last_vec;

   // Digit order 00 -> 01 -> 11 -> 00.
   function automatic logic [1:0] next_digit(input logic [1:0] d);
      case (d)
         2'b00:   return 2'b01;
         2'b01:   return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   assign last_vec = tb_mode && (tb_format == 2'b10) && (tb_n == NLast) &&
                     (tb_d_x_n == 2'b11) && (tb_d_y_n == 2'b11);

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         state     <= StIdle;
         valid     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         vec_cnt   <= '0;
         tb_mode   <= 1'b0;
         tb_format <= 2'b00;
         tb_n      <= '0;
         tb_d_x_n  <= 2'b00;
         tb_d_y_n  <= 2'b00;
      end else if (srst) begin
         // Synchronous reset acts regardless of enable, like the async one.
         state     <= StIdle;
         valid     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         vec_cnt   <= '0;
         tb_mode   <= 1'b0;
         tb_format <= 2'b00;
         tb_n      <= '0;
         tb_d_x_n  <= 2'b00;
         tb_d_y_n  <= 2'b00;
      end else if (enable) begin
         case (state)
            StIdle, StDone: begin
               if (start) begin
                  state     <= StRun;
                  valid     <= 1'b1;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  vec_cnt   <= '0;
                  tb_mode   <= 1'b0;
                  tb_format <= 2'b00;
                  tb_n      <= '0;
                  tb_d_x_n  <= 2'b00;
                  tb_d_y_n  <= 2'b00;
               end
            end
            StRun: begin
               // valid is always 1 in RUN, so ready alone marks a transfer.
               if (ready) begin
                  if (vec_cnt != '1) begin
                     vec_cnt <= vec_cnt + 1'b1;
                  end
                  if (last_vec) begin
                     state <= StDone;
                     valid <= 1'b0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else if (tb_d_y_n != 2'b11) begin
                     tb_d_y_n <= next_digit(tb_d_y_n);
                  end else begin
                     tb_d_y_n <= 2'b00;
                     if (tb_d_x_n != 2'b11) begin
                        tb_d_x_n <= next_digit(tb_d_x_n);
                     end else begin
                        tb_d_x_n <= 2'b00;
                        if (tb_n != NLast) begin
                           tb_n <= tb_n + 1'b1;
                        end else begin
                           tb_n <= '0;
                           if (tb_format != 2'b10) begin
                              tb_format <= tb_format + 2'b01;
                           end else begin
                              tb_format <= 2'b00;
                              tb_mode   <= ~tb_mode;
                           end
                        end
                     end
                  end
               end
            end
            default: begin
               state <= StIdle;
               valid <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lut_decoder_driver.sv
module tb_lut_decoder_driver;

   localparam int unsigned LOG2N = 2;
   localparam int unsigned NLAST = 3;
   localparam int unsigned WCNT  = 16;
   localparam int          TOTAL = 2 * 3 * (NLAST + 1) * 9;

   logic             clk;
   logic             arst;
   logic             srst;
   logic             enable;
   logic             start;
   logic             ready;
   logic             valid;
   logic             tb_mode;
   logic [1:0]       tb_format;
   logic [LOG2N-1:0] tb_n;
   logic [1:0]       tb_d_x_n;
   logic [1:0]       tb_d_y_n;
   logic [WCNT-1:0]  vec_cnt;
   logic             busy;
   logic             done;
   logic [8:0]       obs;

   int total;
   int bad;

   lut_decoder_driver #(
      .WC     (16),
      .WD     (64),
      .LOG2N  (LOG2N),
      .N_LAST (NLAST),
      .WCNT   (WCNT)
   ) dut (
      .clk       (clk),
      .arst      (arst),
      .srst      (srst),
      .enable    (enable),
      .start     (start),
      .ready     (ready),
      .valid     (valid),
      .tb_mode   (tb_mode),
      .tb_format (tb_format),
      .tb_n      (tb_n),
      .tb_d_x_n  (tb_d_x_n),
      .tb_d_y_n  (tb_d_y_n),
      .vec_cnt   (vec_cnt),
      .busy      (busy),
      .done      (done)
   );

   assign obs = {tb_mode, tb_format, tb_n, tb_d_x_n, tb_d_y_n};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Digit value 0, +1, -1 (index 0, 1, 2) to its two-bit code.
   function automatic logic [1:0] enc_digit(input int v);
      if (v == 0) return 2'b00;
      if (v == 1) return 2'b01;
      return 2'b11;
   endfunction

   // Vector k of the sweep, decomposed as a mixed-radix number 2:3:(NLAST+1):3:3.
   function automatic logic [8:0] exp_vec(input int k);
      int dy, dx, n, f, m;
      dy = k % 3;
      dx = (k / 3) % 3;
      n  = (k / 9) % (NLAST + 1);
      f  = (k / (9 * (NLAST + 1))) % 3;
      m  = k / (27 * (NLAST + 1));
      return {m[0], f[1:0], n[1:0], enc_digit(dx), enc_digit(dy)};
   endfunction

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      arst = 1'b0;
      start = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         $display("FAIL reset_flags: got v/b/d=%b%b%b want 000", valid, busy, done);
         bad++;
      end
      total++;
      if (vec_cnt !== '0) begin
         $display("FAIL reset_cnt: got %0d want 0", vec_cnt);
         bad++;
      end
      total++;
      if (obs !== 9'h0) begin
         $display("FAIL reset_vec: got %h want 0", obs);
         bad++;
      end
      start = 1'b0;
      arst = 1'b1;
      @(negedge clk);
      total++;
      if (valid !== 1'b0) begin
         $display("FAIL idle_after_reset: got valid=%b want 0", valid);
         bad++;
      end
   endtask

   task automatic test_order();
      int idx;
      int cyc;
      int fmt11;
      pulse_start();
      ready = 1'b1;
      total++;
      if (valid !== 1'b1 || busy !== 1'b1) begin
         $display("FAIL first_latency: got v/b=%b%b want 11", valid, busy);
         bad++;
      end
      idx = 0;
      cyc = 0;
      fmt11 = 0;
      while (valid === 1'b1 && cyc < 400) begin
         total++;
         if (obs !== exp_vec(idx) || vec_cnt !== WCNT'(idx)) begin
            $display("FAIL order_vec%0d: got %h cnt %0d want %h cnt %0d",
                     idx, obs, vec_cnt, exp_vec(idx), idx);
            bad++;
         end
         if (tb_format == 2'b11) fmt11++;
         if (idx == 9) begin
            total++;
            if (tb_n !== 2'd1) begin
               $display("FAIL order_n_carry: got n=%0d want 1", tb_n);
               bad++;
            end
         end
         if (idx == 36) begin
            total++;
            if (tb_format !== 2'b01) begin
               $display("FAIL order_fmt_carry: got %b want 01", tb_format);
               bad++;
            end
         end
         if (idx == 108) begin
            total++;
            if (tb_mode !== 1'b1) begin
               $display("FAIL order_mode_carry: got %b want 1", tb_mode);
               bad++;
            end
         end
         idx++;
         @(negedge clk);
         cyc++;
      end
      total++;
      if (fmt11 != 0) begin
         $display("FAIL order_fmt11: got %0d occurrences want 0", fmt11);
         bad++;
      end
      total++;
      if (idx != TOTAL || done !== 1'b1 || busy !== 1'b0 || valid !== 1'b0) begin
         $display("FAIL order_end: got n=%0d d/b/v=%b%b%b want n=%0d 100",
                  idx, done, busy, valid, TOTAL);
         bad++;
      end
      total++;
      if (vec_cnt !== WCNT'(TOTAL)) begin
         $display("FAIL order_cnt: got %0d want %0d", vec_cnt, TOTAL);
         bad++;
      end
   endtask

   task automatic test_restart_done();
      int idx;
      int cyc;
      total++;
      if (done !== 1'b1) begin
         $display("FAIL restart_pre_done: got %b want 1", done);
         bad++;
      end
      pulse_start();
      ready = 1'b1;
      total++;
      if (done !== 1'b0 || valid !== 1'b1 || busy !== 1'b1 || vec_cnt !== '0 || obs !== 9'h0) begin
         $display("FAIL restart_entry: got d/v/b=%b%b%b cnt %0d vec %h want 011 0 0",
                  done, valid, busy, vec_cnt, obs);
         bad++;
      end
      idx = 0;
      cyc = 0;
      while (valid === 1'b1 && cyc < 400) begin
         total++;
         if (obs !== exp_vec(idx) || vec_cnt !== WCNT'(idx)) begin
            $display("FAIL restart_vec%0d: got %h cnt %0d want %h", idx, obs, vec_cnt, exp_vec(idx));
            bad++;
         end
         // A start in RUN must not disturb the sweep.
         start = (idx == 30);
         idx++;
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      total++;
      if (idx != TOTAL || done !== 1'b1 || vec_cnt !== WCNT'(TOTAL)) begin
         $display("FAIL restart_end: got n=%0d done=%b cnt=%0d want %0d 1 %0d",
                  idx, done, vec_cnt, TOTAL, TOTAL);
         bad++;
      end
   endtask

   task automatic test_backpressure();
      int         idx;
      int         cyc;
      logic [8:0] prev;
      logic       held;
      pulse_start();
      idx = 0;
      cyc = 0;
      held = 1'b0;
      prev = '0;
      while (valid === 1'b1 && cyc < 2000) begin
         if (held) begin
            total++;
            if (obs !== prev) begin
               $display("FAIL bp_stable: got %h want %h", obs, prev);
               bad++;
            end
         end
         total++;
         if (obs !== exp_vec(idx) || vec_cnt !== WCNT'(idx)) begin
            $display("FAIL bp_vec%0d: got %h cnt %0d want %h", idx, obs, vec_cnt, exp_vec(idx));
            bad++;
         end
         ready = 1'($urandom_range(0, 1));
         held = !ready;
         prev = obs;
         if (ready) idx++;
         @(negedge clk);
         cyc++;
      end
      ready = 1'b1;
      total++;
      if (idx != TOTAL || done !== 1'b1 || vec_cnt !== WCNT'(TOTAL)) begin
         $display("FAIL bp_end: got n=%0d done=%b cnt=%0d want %0d 1 %0d",
                  idx, done, vec_cnt, TOTAL, TOTAL);
         bad++;
      end
   endtask

   task automatic test_enable_freeze();
      int idx;
      int cyc;
      bit froze;
      pulse_start();
      ready = 1'b1;
      idx = 0;
      cyc = 0;
      froze = 0;
      while (valid === 1'b1 && cyc < 400) begin
         total++;
         if (obs !== exp_vec(idx) || vec_cnt !== WCNT'(idx)) begin
            $display("FAIL en_vec%0d: got %h cnt %0d want %h", idx, obs, vec_cnt, exp_vec(idx));
            bad++;
         end
         if (idx == 50 && !froze) begin
            froze = 1;
            enable = 1'b0;
            for (int j = 0; j < 5; j++) begin
               @(negedge clk);
               cyc++;
               total++;
               if (vec_cnt !== WCNT'(50) || obs !== exp_vec(50) || valid !== 1'b1) begin
                  $display("FAIL en_freeze%0d: got cnt %0d vec %h v=%b want 50 %h 1",
                           j, vec_cnt, obs, valid, exp_vec(50));
                  bad++;
               end
            end
            enable = 1'b1;
         end
         idx++;
         @(negedge clk);
         cyc++;
      end
      total++;
      if (idx != TOTAL || done !== 1'b1 || vec_cnt !== WCNT'(TOTAL)) begin
         $display("FAIL en_end: got n=%0d done=%b cnt=%0d want %0d 1 %0d",
                  idx, done, vec_cnt, TOTAL, TOTAL);
         bad++;
      end
   endtask

   task automatic test_midsweep_reset();
      int idx;
      int cyc;
      pulse_start();
      ready = 1'b1;
      idx = 0;
      cyc = 0;
      while (valid === 1'b1 && idx < 100 && cyc < 400) begin
         idx++;
         @(negedge clk);
         cyc++;
      end
      total++;
      if (vec_cnt !== WCNT'(100) || obs !== exp_vec(100)) begin
         $display("FAIL srst_pre: got cnt %0d vec %h want 100 %h", vec_cnt, obs, exp_vec(100));
         bad++;
      end
      srst = 1'b1;
      @(negedge clk);
      srst = 1'b0;
      total++;
      if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || vec_cnt !== '0 || obs !== 9'h0) begin
         $display("FAIL srst_abort: got v/b/d=%b%b%b cnt %0d vec %h want 000 0 0",
                  valid, busy, done, vec_cnt, obs);
         bad++;
      end
      repeat (2) @(negedge clk);
      total++;
      if (valid !== 1'b0) begin
         $display("FAIL srst_needs_start: got valid=%b want 0", valid);
         bad++;
      end
      pulse_start();
      for (int k = 0; k < 12; k++) begin
         total++;
         if (valid !== 1'b1 || obs !== exp_vec(k) || vec_cnt !== WCNT'(k)) begin
            $display("FAIL srst_restart%0d: got v=%b vec %h cnt %0d want 1 %h %0d",
                     k, valid, obs, vec_cnt, exp_vec(k), k);
            bad++;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      total  = 0;
      bad    = 0;
      arst   = 1'b0;
      srst   = 1'b0;
      enable = 1'b1;
      start  = 1'b0;
      ready  = 1'b0;
      @(negedge clk);
      test_reset();
      test_order();
      test_restart_done();
      test_backpressure();
      test_enable_freeze();
      test_midsweep_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
